// File: rtl/calc_ctrl_pkg.sv
// Shared types and constants for the simple-calc button front end.
package calc_ctrl_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_RUN
  } rpt_state_t;

  localparam int unsigned BTN_CENTER = 0;
  localparam int unsigned BTN_UP     = 1;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_LEFT   = 3;
  localparam int unsigned BTN_RIGHT  = 4;

  localparam int unsigned NUM_BTN_DEFAULT  = 5;
  localparam logic [4:0]  RPT_MASK_DEFAULT = 5'b00110;

endpackage

// File: rtl/calc_btn_sequencer_if.sv
// Command handshake between the button sequencer and the calculator control FSM.
interface calc_btn_sequencer_if #(
  parameter int unsigned NUM_BTN = 5
);
  localparam int unsigned IdW = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;

  logic           CMD_VALID;
  logic [IdW-1:0] CMD_ID;
  logic           CMD_REPEAT;
  logic           CMD_READY;
  logic           CMD_DROP;

  modport master (
    output CMD_VALID,
    output CMD_ID,
    output CMD_REPEAT,
    output CMD_DROP,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID,
    input  CMD_ID,
    input  CMD_REPEAT,
    input  CMD_DROP,
    output CMD_READY
  );
endinterface

// File: rtl/btn_prio_enc.sv
// Fixed-priority encoder: lowest set index wins, plus an any-set flag.
module btn_prio_enc #(
  parameter int unsigned N   = 5,
  parameter int unsigned IdW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   i_req,
  output logic [IdW-1:0] o_idx,
  output logic           o_any
);

  // Descending scan so the last hit (lowest index) takes effect.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IdW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/calc_btn_sequencer.sv
// Converts debounced button levels into prioritised press / auto-repeat commands
// delivered over a valid/ready handshake.
module calc_btn_sequencer
  import calc_ctrl_pkg::*;
#(
  parameter int unsigned        NUM_BTN      = NUM_BTN_DEFAULT,
  parameter int unsigned        REPEAT_DELAY = 500,
  parameter int unsigned        REPEAT_RATE  = 100,
  parameter logic [NUM_BTN-1:0] RPT_MASK     = RPT_MASK_DEFAULT
) (
  input  logic                 CLOCK,
  input  logic                 CPU_RESET,
  input  logic [NUM_BTN-1:0]   BTN_LVL,
  calc_btn_sequencer_if.master io_cmd
);

  localparam int unsigned IdW    = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1;
  localparam int unsigned CntMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  logic [NUM_BTN-1:0] r_prev, r_pend, w_pend_nxt, w_rise, w_req;
  logic               r_valid, w_valid_nxt;
  logic [IdW-1:0]     r_id, w_id_nxt;
  logic               r_repeat, w_repeat_nxt;
  logic               r_drop, w_drop_nxt;
  rpt_state_t         r_state, w_state_nxt;
  logic [IdW-1:0]     r_owner, w_owner_nxt;
  logic [CntW-1:0]    r_cnt, w_cnt_nxt, w_term;
  logic               r_rpt_pend, w_rpt_pend_nxt;
  logic [IdW-1:0]     w_idx;
  logic               w_any, w_free, w_load_orig, w_load_rpt;

  assign w_rise      = BTN_LVL & ~r_prev;
  assign w_req       = r_pend | w_rise;
  assign w_free      = ~r_valid | io_cmd.CMD_READY;
  assign w_load_orig = w_free & w_any;
  assign w_load_rpt  = w_free & ~w_any & r_rpt_pend;
  assign w_drop_nxt  = |(w_rise & r_pend);

  btn_prio_enc #(
    .N  (NUM_BTN),
    .IdW(IdW)
  ) u_prio (
    .i_req(w_req),
    .o_idx(w_idx),
    .o_any(w_any)
  );

  always_comb begin
    w_pend_nxt   = w_req;
    w_valid_nxt  = r_valid;
    w_id_nxt     = r_id;
    w_repeat_nxt = r_repeat;
    if (w_load_orig) begin
      w_valid_nxt  = 1'b1;
      w_id_nxt     = w_idx;
      w_repeat_nxt = 1'b0;
      w_pend_nxt   = w_req & ~(NUM_BTN'(1) << w_idx);
    end else if (w_load_rpt) begin
      w_valid_nxt  = 1'b1;
      w_id_nxt     = r_owner;
      w_repeat_nxt = 1'b1;
    end else if (w_free) begin
      w_valid_nxt  = 1'b0;
    end
  end

  assign w_term = (r_state == RPT_DELAY) ? CntW'(REPEAT_DELAY - 1) : CntW'(REPEAT_RATE - 1);

  // Repeat FSM: release beats terminal count; a new repeat-enabled press steals ownership.
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_cnt_nxt      = r_cnt;
    w_rpt_pend_nxt = r_rpt_pend & ~w_load_rpt;
    unique case (r_state)
      RPT_DELAY, RPT_RUN: begin
        if (!BTN_LVL[r_owner]) begin
          w_state_nxt    = RPT_IDLE;
          w_cnt_nxt      = '0;
          w_rpt_pend_nxt = 1'b0;
        end else if (r_cnt == w_term) begin
          w_state_nxt    = RPT_RUN;
          w_cnt_nxt      = '0;
          w_rpt_pend_nxt = 1'b1;
        end else begin
          w_cnt_nxt      = r_cnt + 1'b1;
        end
      end
      default: ;
    endcase
    if (w_load_orig && RPT_MASK[w_idx]) begin
      w_state_nxt    = RPT_DELAY;
      w_owner_nxt    = w_idx;
      w_cnt_nxt      = '0;
      w_rpt_pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or posedge CPU_RESET) begin
    if (CPU_RESET) begin
      r_prev     <= '0;
      r_pend     <= '0;
      r_valid    <= 1'b0;
      r_id       <= '0;
      r_repeat   <= 1'b0;
      r_drop     <= 1'b0;
      r_state    <= RPT_IDLE;
      r_owner    <= '0;
      r_cnt      <= '0;
      r_rpt_pend <= 1'b0;
    end else begin
      r_prev     <= BTN_LVL;
      r_pend     <= w_pend_nxt;
      r_valid    <= w_valid_nxt;
      r_id       <= w_id_nxt;
      r_repeat   <= w_repeat_nxt;
      r_drop     <= w_drop_nxt;
      r_state    <= w_state_nxt;
      r_owner    <= w_owner_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rpt_pend <= w_rpt_pend_nxt;
    end
  end

  assign io_cmd.CMD_VALID  = r_valid;
  assign io_cmd.CMD_ID     = r_id;
  assign io_cmd.CMD_REPEAT = r_repeat;
  assign io_cmd.CMD_DROP   = r_drop;

endmodule
